// File: rtl/gobang_pkg.sv
// gobang_pkg: shared constants and helpers for the gobang board datapath.
//   BOARD_N / WIN_LEN / WIN_HALF / CELLS : board and window geometry
//   BLACK / WHITE                        : stone color encoding on write_color
//   cell_index()                         : flat bit index of an on-board cell
//   cell_at()                            : read one cell, 0 when the cell is off the board
package gobang_pkg;

  localparam int BOARD_N  = 15;
  localparam int WIN_LEN  = 9;
  localparam int WIN_HALF = 4;
  localparam int CELLS    = BOARD_N * BOARD_N;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  // Coordinate value 15 is the "no cell" marker on every 4-bit coordinate port.
  localparam logic [3:0] COORD_NONE = 4'd15;

  // Signed window coordinates are 6 bits wide: a query of 0..14 plus an offset
  // of -4..+4 spans -4..18, which must not wrap into the board.
  typedef logic signed [5:0] coord_t;

  localparam coord_t COORD_MIN = 6'sd0;
  localparam coord_t COORD_MAX = 6'sd14;

  function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return 8'(y) * 8'(BOARD_N) + 8'(x);
  endfunction

  // Off-board cells read as empty so windows near an edge are zero-filled
  // instead of picking up stones from a neighbouring row.
  function automatic logic cell_at(input logic [CELLS-1:0] map,
                                   input coord_t           x,
                                   input coord_t           y);
    if (x < COORD_MIN || x > COORD_MAX || y < COORD_MIN || y > COORD_MAX)
      return 1'b0;
    return map[cell_index(x[3:0], y[3:0])];
  endfunction

endpackage

// File: rtl/gobang_window.sv
// gobang_window: extracts the four 9-cell lines through a query cell from one
// color's occupancy map. Purely combinational.
//   map    in  225  occupancy map, bit index = y*15 + x
//   get_x  in  4    query column (15 = no query)
//   get_y  in  4    query row    (15 = no query)
//   win_x  out 9    horizontal line, bit k = cell (x+k-4, y)
//   win_y  out 9    vertical line,   bit k = cell (x, y+k-4)
//   win_xy out 9    main diagonal,   bit k = cell (x+k-4, y+k-4)
//   win_yx out 9    anti-diagonal,   bit k = cell (x+k-4, y-(k-4))
module gobang_window
  import gobang_pkg::*;
(
  input  logic [CELLS-1:0]   map,
  input  logic [3:0]         get_x,
  input  logic [3:0]         get_y,
  output logic [WIN_LEN-1:0] win_x,
  output logic [WIN_LEN-1:0] win_y,
  output logic [WIN_LEN-1:0] win_xy,
  output logic [WIN_LEN-1:0] win_yx
);

  coord_t gx;
  coord_t gy;

  assign gx = coord_t'({2'b00, get_x});
  assign gy = coord_t'({2'b00, get_y});

  // NOTE: every output gets a default before any conditional assignment so
  // this block stays purely combinational and no latch is inferred.
  always_comb begin
    coord_t d;
    win_x  = '0;
    win_y  = '0;
    win_xy = '0;
    win_yx = '0;
    d      = '0;
    // A query at 15 is "no query": without this guard an offset of -1 would
    // land on row/column 14 and report real stones.
    if (get_x != COORD_NONE && get_y != COORD_NONE) begin
      for (int k = 0; k < WIN_LEN; k++) begin
        d         = coord_t'(k - WIN_HALF);
        win_x[k]  = cell_at(map, gx + d, gy);
        win_y[k]  = cell_at(map, gx,     gy + d);
        win_xy[k] = cell_at(map, gx + d, gy + d);
        win_yx[k] = cell_at(map, gx + d, gy - d);
      end
    end
  end

endmodule

// File: rtl/gobang_datapath.sv
// gobang_datapath: 15x15 gobang board state with per-color line windows.
//   clk                          in   1    rising-edge clock
//   rst                          in   1    synchronous active-high reset, clears board
//   clr                          in   1    synchronous board clear (below rst)
//   write                        in   1    place a stone this cycle (below clr)
//   write_x, write_y             in   4    target cell; 15 on either axis ignores the write
//   write_color                  in   1    0 = black, 1 = white
//   get_x, get_y                 in   4    query cell for the windows
//   black_x/_y/_xy/_yx           out  9    black lines through the query cell
//   white_x/_y/_xy/_yx           out  9    white lines through the query cell
//   black_data, white_data       out  225  occupancy maps, bit index = y*15 + x
module gobang_datapath
  import gobang_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               write,
  input  logic [3:0]         write_x,
  input  logic [3:0]         write_y,
  input  logic               write_color,
  input  logic [3:0]         get_x,
  input  logic [3:0]         get_y,
  output logic [WIN_LEN-1:0] black_x,
  output logic [WIN_LEN-1:0] black_y,
  output logic [WIN_LEN-1:0] black_xy,
  output logic [WIN_LEN-1:0] black_yx,
  output logic [WIN_LEN-1:0] white_x,
  output logic [WIN_LEN-1:0] white_y,
  output logic [WIN_LEN-1:0] white_xy,
  output logic [WIN_LEN-1:0] white_yx,
  output logic [CELLS-1:0]   black_data,
  output logic [CELLS-1:0]   white_data
);

  logic [CELLS-1:0] black_q;
  logic [CELLS-1:0] white_q;
  logic             wr_ok;
  logic [CELLS-1:0] wr_mask;

  assign wr_ok   = write && (write_x != COORD_NONE) && (write_y != COORD_NONE);
  assign wr_mask = {{(CELLS-1){1'b0}}, 1'b1} << cell_index(write_x, write_y);

  // The maps are plain flops rather than a RAM: every bit feeds the window
  // logic in parallel, and the whole board must clear in one edge.
  // NOTE: state is updated with non-blocking assignments so both maps see the
  // pre-edge values of each other within the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      black_q <= '0;
      white_q <= '0;
    end else if (clr) begin
      black_q <= '0;
      white_q <= '0;
    end else if (wr_ok) begin
      // Placing a stone takes the cell away from the other color, so a cell
      // is never owned by both maps.
      if (write_color == WHITE) begin
        white_q <= white_q | wr_mask;
        black_q <= black_q & ~wr_mask;
      end else begin
        black_q <= black_q | wr_mask;
        white_q <= white_q & ~wr_mask;
      end
    end
  end

  assign black_data = black_q;
  assign white_data = white_q;

  gobang_window u_black_window (
    .map    (black_q),
    .get_x  (get_x),
    .get_y  (get_y),
    .win_x  (black_x),
    .win_y  (black_y),
    .win_xy (black_xy),
    .win_yx (black_yx)
  );

  gobang_window u_white_window (
    .map    (white_q),
    .get_x  (get_x),
    .get_y  (get_y),
    .win_x  (white_x),
    .win_y  (white_y),
    .win_xy (white_xy),
    .win_yx (white_yx)
  );

endmodule

// File: tb/tb_gobang_datapath.sv
// tb_gobang_datapath: directed scoreboard bench for gobang_datapath.
// Stimulus pushes hand-computed expected outputs; a monitor pops and compares
// on the falling edge.
module tb_gobang_datapath;
  import gobang_pkg::*;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             write;
  logic [3:0]       write_x;
  logic [3:0]       write_y;
  logic             write_color;
  logic [3:0]       get_x;
  logic [3:0]       get_y;
  logic [8:0]       black_x, black_y, black_xy, black_yx;
  logic [8:0]       white_x, white_y, white_xy, white_yx;
  logic [CELLS-1:0] black_data, white_data;

  gobang_datapath dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .write       (write),
    .write_x     (write_x),
    .write_y     (write_y),
    .write_color (write_color),
    .get_x       (get_x),
    .get_y       (get_y),
    .black_x     (black_x),
    .black_y     (black_y),
    .black_xy    (black_xy),
    .black_yx    (black_yx),
    .white_x     (white_x),
    .white_y     (white_y),
    .white_xy    (white_xy),
    .white_yx    (white_yx),
    .black_data  (black_data),
    .white_data  (white_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [CELLS-1:0] bd;
    logic [CELLS-1:0] wd;
    logic [8:0]       bx, by, bxy, byx;
    logic [8:0]       wx, wy, wxy, wyx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [8:0] Z  = 9'b000000000;
  localparam logic [8:0] C4 = 9'b000010000;

  function automatic logic [CELLS-1:0] bit_at(input int idx);
    logic [CELLS-1:0] one;
    one = '0;
    one[idx] = 1'b1;
    return one;
  endfunction

  function automatic exp_t mk(input string name,
                              input logic [CELLS-1:0] bd, input logic [CELLS-1:0] wd,
                              input logic [8:0] bx, input logic [8:0] by,
                              input logic [8:0] bxy, input logic [8:0] byx,
                              input logic [8:0] wx, input logic [8:0] wy,
                              input logic [8:0] wxy, input logic [8:0] wyx);
    exp_t e;
    e.name = name; e.bd = bd; e.wd = wd;
    e.bx = bx; e.by = by; e.bxy = bxy; e.byx = byx;
    e.wx = wx; e.wy = wy; e.wxy = wxy; e.wyx = wyx;
    return e;
  endfunction

  task automatic chk(input string name, input string field,
                     input logic [CELLS-1:0] act, input logic [CELLS-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: compares the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "black_data", black_data, e.bd);
        chk(e.name, "white_data", white_data, e.wd);
        chk(e.name, "black_x",  CELLS'(black_x),  CELLS'(e.bx));
        chk(e.name, "black_y",  CELLS'(black_y),  CELLS'(e.by));
        chk(e.name, "black_xy", CELLS'(black_xy), CELLS'(e.bxy));
        chk(e.name, "black_yx", CELLS'(black_yx), CELLS'(e.byx));
        chk(e.name, "white_x",  CELLS'(white_x),  CELLS'(e.wx));
        chk(e.name, "white_y",  CELLS'(white_y),  CELLS'(e.wy));
        chk(e.name, "white_xy", CELLS'(white_xy), CELLS'(e.wxy));
        chk(e.name, "white_yx", CELLS'(white_yx), CELLS'(e.wyx));
      end
    end
  end

  // One clock edge with the given controls, then expect e with the given query.
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [3:0] wx, input logic [3:0] wy, input logic col,
                      input logic [3:0] gx, input logic [3:0] gy, input exp_t e);
    rst = r; clr = c; write = w;
    write_x = wx; write_y = wy; write_color = col;
    get_x = gx; get_y = gy;
    @(posedge clk);
    #1;
    rst = 1'b0; clr = 1'b0; write = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Change only the query cell and expect e before the next edge.
  task automatic peek(input logic [3:0] gx, input logic [3:0] gy, input exp_t e);
    get_x = gx; get_y = gy;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CELLS-1:0] b16, w17, w16, b0, b224, w14, b112;
    int               wait_cycles;
    b16  = bit_at(16);
    w17  = bit_at(17);
    w16  = bit_at(16);
    b0   = bit_at(0);
    b224 = bit_at(224);
    w14  = bit_at(14);
    b112 = bit_at(112);

    rst = 1'b1; clr = 1'b0; write = 1'b0;
    write_x = '0; write_y = '0; write_color = 1'b0;
    get_x = 4'd1; get_y = 4'd1;
    @(negedge clk);
    #1;

    // Reset with query (1,1): everything zero.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, BLACK, 4'd1, 4'd1,
         mk("reset", '0, '0, Z, Z, Z, Z, Z, Z, Z, Z));

    // Black at (1,1): centre bit of every black window.
    step(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, BLACK, 4'd1, 4'd1,
         mk("black_write", b16, '0, C4, C4, C4, C4, Z, Z, Z, Z));

    // White at (2,1): one cell right of the query, bit5 of white_x only.
    step(1'b0, 1'b0, 1'b1, 4'd2, 4'd1, WHITE, 4'd1, 4'd1,
         mk("white_write", b16, w17, C4, C4, C4, C4, 9'b000100000, Z, Z, Z));

    // write=0 with a valid address leaves both maps alone.
    step(1'b0, 1'b0, 1'b0, 4'd5, 4'd5, WHITE, 4'd1, 4'd1,
         mk("no_write", b16, w17, C4, C4, C4, C4, 9'b000100000, Z, Z, Z));

    // White over black at (1,1).
    step(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, WHITE, 4'd1, 4'd1,
         mk("overwrite", '0, w16 | w17, Z, Z, Z, Z, 9'b000110000, C4, C4, C4));

    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, BLACK, 4'd1, 4'd1,
         mk("clear", '0, '0, Z, Z, Z, Z, Z, Z, Z, Z));

    // Corner stones; (14,14) is outside the window of (0,0).
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, BLACK, 4'd0, 4'd0,
         mk("corner_00", b0, '0, C4, C4, C4, C4, Z, Z, Z, Z));
    step(1'b0, 1'b0, 1'b1, 4'd14, 4'd14, BLACK, 4'd0, 4'd0,
         mk("corner_1414", b0 | b224, '0, C4, C4, C4, C4, Z, Z, Z, Z));
    peek(4'd14, 4'd14,
         mk("get_1414", b0 | b224, '0, C4, C4, C4, C4, Z, Z, Z, Z));
    peek(4'd10, 4'd10,
         mk("get_1010", b0 | b224, '0, Z, Z, 9'b100000000, Z, Z, Z, Z, Z));

    // Query 15 on either axis blanks windows even next to a stone at 14.
    peek(4'd15, 4'd14,
         mk("get_x15", b0 | b224, '0, Z, Z, Z, Z, Z, Z, Z, Z));
    peek(4'd14, 4'd15,
         mk("get_y15", b0 | b224, '0, Z, Z, Z, Z, Z, Z, Z, Z));

    // White at (14,0) is flat index 14, same as (-1,1); must not alias.
    step(1'b0, 1'b0, 1'b1, 4'd14, 4'd0, WHITE, 4'd0, 4'd1,
         mk("neg_offset", b0 | b224, w14, Z, 9'b000001000, Z, Z, Z, Z, Z, Z));

    // Write at column 15 is ignored.
    step(1'b0, 1'b0, 1'b1, 4'd15, 4'd3, BLACK, 4'd0, 4'd1,
         mk("ignored_x15", b0 | b224, w14, Z, 9'b000001000, Z, Z, Z, Z, Z, Z));

    // clr beats write.
    step(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, BLACK, 4'd7, 4'd7,
         mk("clr_over_write", '0, '0, Z, Z, Z, Z, Z, Z, Z, Z));

    step(1'b0, 1'b0, 1'b1, 4'd7, 4'd7, BLACK, 4'd7, 4'd7,
         mk("black_77", b112, '0, C4, C4, C4, C4, Z, Z, Z, Z));

    // rst beats write and clears the existing stone.
    step(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, WHITE, 4'd7, 4'd7,
         mk("rst_over_write", '0, '0, Z, Z, Z, Z, Z, Z, Z, Z));

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gobang_datapath.md
GOBANG_DATAPATH -- requirements
Module: gobang_datapath

Interface
REQ-001 Parameters: none. Board size is fixed at 15, window length at 9, window half-width at 4.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 clr  in  1  synchronous board clear.
REQ-005 write  in  1  place a stone this cycle.
REQ-006 write_x  in  4  write column, 0..14.
REQ-007 write_y  in  4  write row, 0..14.
REQ-008 write_color  in  1  stone color: 0 = black, 1 = white.
REQ-009 get_x  in  4  query column, 0..14.
REQ-010 get_y  in  4  query row, 0..14.
REQ-011 black_x, black_y, black_xy, black_yx  out  9 each  black-stone windows through the query cell: horizontal, vertical, main diagonal, anti-diagonal.
REQ-012 white_x, white_y, white_xy, white_yx  out  9 each  the same four windows for white stones.
REQ-013 black_data, white_data  out  225 each  full occupancy maps; bit index = y*15 + x.

Function
REQ-014 State: two 225-bit registers, one per color; all outputs derive from these registers.
REQ-015 black_data and white_data SHALL equal the registers directly, with zero-cycle latency from register to output.
REQ-016 A write with write=1 and both coordinates in 0..14 SHALL, at the next edge, set the addressed bit in the selected color map and clear the same bit in the other color map.
REQ-017 A write with either coordinate equal to 15 SHALL be ignored.
REQ-018 A write with write=0 leaves both maps unchanged.
REQ-019 clr=1 SHALL zero both maps at the next edge. Priority: rst > clr > write.
REQ-020 Window bit k (k = 0..8) SHALL use offset d = k-4 as follows:
  - _x: cell (get_x+d, get_y)
  - _y: cell (get_x, get_y+d)
  - _xy: cell (get_x+d, get_y+d)
  - _yx: cell (get_x+d, get_y-d)
REQ-021 Window bits whose cell lies outside 0..14 on either axis SHALL read 0.
REQ-022 A query coordinate equal to 15 SHALL make every bit of every window 0.
REQ-023 Windows SHALL be combinational from the registers and get_x/get_y. A write becomes visible in the windows in the cycle after its edge.
REQ-024 A black window and the matching white window SHALL never have the same bit set.
REQ-025 Window extraction SHALL use index arithmetic at least 5 bits wide, signed or offset-biased, so that negative offsets do not wrap around.

Reset
REQ-026 rst=1 at a rising edge SHALL zero both maps. All 8 window outputs and both data outputs then read 0.
REQ-027 rst asserted while write=1 SHALL discard the write.

Structure
REQ-028 The shared package gobang_pkg SHALL hold:
  - BOARD_N = 15
  - WIN_LEN = 9
  - WIN_HALF = 4
  - CELLS = 225
  - the color encoding constants BLACK = 0 and WHITE = 1
REQ-029 One sub-module, gobang_window, SHALL take a 225-bit map plus get_x/get_y and return the four 9-bit windows.
REQ-030 gobang_window SHALL be instantiated twice, once for black and once for white. The top level holds the registers and write/clear logic.

Verification
REQ-031 Reset: rst=1 for 1 edge, get=(1,1) -> all outputs 0.
REQ-032 Black write: rst=0, write=1 at (1,1), color 0, for one edge -> black_data[16]=1; black_x=black_y=black_xy=black_yx=9'b000010000; white_* all 0.
REQ-033 White write: write=1 at (2,1), color 1 -> white_data[17]=1; with get=(1,1), white_x=9'b000100000 (bit5) and white_xy=0.
REQ-034 Overwrite and clear:
  - White write at (1,1) -> black_data[16]=0 and white_data[16]=1.
  - Then clr=1 for one edge -> both maps 0.
REQ-035 Edge windows:
  - Black stones at (0,0) and (14,14), get=(0,0) -> black_x bits 0..3 zero, bit4=1; black_xy bit4 only.
  - get=(14,14) -> black_xy=9'b000010000.
  - get=(10,10) -> black_xy bit8=1.
REQ-036 Ignored write and priority:
  - write at (15,3) -> maps unchanged.
  - write=1 together with clr=1 -> maps 0 after the edge.
